// File: rtl/serial_link_pkg.sv
// Shared definitions for the Messenger serial link (encoder and decoder).
// Holds line levels, the frame FSM state type and the parity helper.
package serial_link_pkg;

   localparam int unsigned DATA_BITS = 8;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } state_e;

   // Even-parity bit for a character: XOR of all data bits.
   function automatic logic parity_even(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter for the serial decoder; tick_o is a registered
// one-cycle strobe on the edge where the counter reaches zero.
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_half_i,
   input  logic load_full_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;
   logic             tick_q;

   // A reload of N makes the consumer see the tick N+1 edges after the load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else if (load_half_i) begin
         count_q <= HALF_RELOAD;
         tick_q  <= (HALF_RELOAD == '0);
      end else if (load_full_i) begin
         count_q <= FULL_RELOAD;
         tick_q  <= (FULL_RELOAD == '0);
      end else if (count_q != '0) begin
         count_q <= count_q - CNT_W'(1);
         tick_q  <= (count_q == CNT_W'(1));
      end else begin
         tick_q  <= 1'b0;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/serial_decoder.sv
// Receive half of the Messenger serial link: recovers 8-bit characters from the
// idle-high one-wire stream (start, 8 data LSB first, optional even parity, stop).
module serial_decoder
   import serial_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] parallel_out,
   output logic                 data_valid,
   output logic                 parity_error,
   output logic                 frame_error,
   output logic                 busy,
   output logic [7:0]           char_count
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   state_e               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [IDX_W-1:0]     bit_idx_q;
   logic                 par_err_q;
   logic [DATA_BITS-1:0] parallel_out_q;
   logic                 data_valid_q;
   logic                 parity_error_q;
   logic                 frame_error_q;
   logic                 busy_q;
   logic [7:0]           char_count_q;

   logic tick;
   logic load_half_c;
   logic load_full_c;

   // The timer must be loaded on the same edge the FSM moves, so loads are combinational.
   assign load_half_c = (state_q == ST_IDLE) && (serial_in == START_LVL);
   assign load_full_c = tick && ((state_q == ST_START) || (state_q == ST_DATA) ||
                                 (state_q == ST_PARITY));

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i       (clock),
      .rst_i       (reset),
      .load_half_i (load_half_c),
      .load_full_i (load_full_c),
      .tick_o      (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         shift_q        <= '0;
         bit_idx_q      <= '0;
         par_err_q      <= 1'b0;
         parallel_out_q <= '0;
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         busy_q         <= 1'b0;
         char_count_q   <= '0;
      end else begin
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (serial_in == START_LVL) begin
                  state_q   <= ST_START;
                  busy_q    <= 1'b1;
                  bit_idx_q <= '0;
                  par_err_q <= 1'b0;
               end
            end
            ST_START: begin
               // Mid-bit re-check rejects glitches shorter than half a bit.
               if (tick) begin
                  if (serial_in != START_LVL) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_q   <= {serial_in, shift_q[DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == LAST_IDX) begin
                     state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  par_err_q <= parity_even(shift_q) ^ serial_in;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (serial_in == STOP_LVL) begin
                     if (par_err_q) begin
                        parity_error_q <= 1'b1;
                     end else begin
                        parallel_out_q <= shift_q;
                        data_valid_q   <= 1'b1;
                        char_count_q   <= char_count_q + 8'd1;
                     end
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     frame_error_q  <= 1'b1;
                     parity_error_q <= par_err_q;
                     state_q        <= ST_WAIT_IDLE;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               // Break or stuck-low line: hold off until the line returns high.
               if (serial_in == IDLE_LVL) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign parallel_out = parallel_out_q;
   assign data_valid   = data_valid_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign busy         = busy_q;
   assign char_count   = char_count_q;

endmodule

// File: tb/tb_serial_decoder.sv
// Self-checking bench for serial_decoder: a parity build (dut) and a no-parity
// build (dut_np), each with a model-driven scoreboard of expected pulses.
module tb_serial_decoder;

   localparam int unsigned C = 4;

   logic       clock = 1'b0;
   logic       rst0, rst1, ser0, ser1;
   logic [7:0] po0, po1, cnt0, cnt1;
   logic       dv0, pe0, fe0, busy0;
   logic       dv1, pe1, fe1, busy1;

   always #5 clock = ~clock;

   serial_decoder #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut (
      .clock(clock), .reset(rst0), .serial_in(ser0), .parallel_out(po0),
      .data_valid(dv0), .parity_error(pe0), .frame_error(fe0), .busy(busy0),
      .char_count(cnt0));

   serial_decoder #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut_np (
      .clock(clock), .reset(rst1), .serial_in(ser1), .parallel_out(po1),
      .data_valid(dv1), .parity_error(pe1), .frame_error(fe1), .busy(busy1),
      .char_count(cnt1));

   typedef struct {
      logic       dv;
      logic       pe;
      logic       fe;
      logic [7:0] data;
      logic [7:0] cnt;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_dv_cyc0 = -1;
   logic [7:0] m_out[2];
   logic [7:0] m_cnt[2];

   always @(posedge clock) cyc++;

   // Scoreboard for the parity build: every pulse must match the next expectation.
   always @(negedge clock) begin
      exp_t e;
      if (dv0 || pe0 || fe0) begin
         tests++;
         if (q0.size() == 0) begin
            fails++;
            $display("FAIL dut_unexpected_pulse: dv=%b pe=%b fe=%b out=%h, required no pulse",
                     dv0, pe0, fe0, po0);
         end else begin
            e = q0.pop_front();
            if ({dv0, pe0, fe0, po0, cnt0} !== {e.dv, e.pe, e.fe, e.data, e.cnt}) begin
               fails++;
               $display("FAIL dut_pulse: got dv=%b pe=%b fe=%b out=%h cnt=%0d, required dv=%b pe=%b fe=%b out=%h cnt=%0d",
                        dv0, pe0, fe0, po0, cnt0, e.dv, e.pe, e.fe, e.data, e.cnt);
            end
         end
         if (dv0) last_dv_cyc0 = cyc;
      end
   end

   // Scoreboard for the no-parity build.
   always @(negedge clock) begin
      exp_t e;
      if (dv1 || pe1 || fe1) begin
         tests++;
         if (q1.size() == 0) begin
            fails++;
            $display("FAIL np_unexpected_pulse: dv=%b pe=%b fe=%b out=%h, required no pulse",
                     dv1, pe1, fe1, po1);
         end else begin
            e = q1.pop_front();
            if ({dv1, pe1, fe1, po1, cnt1} !== {e.dv, e.pe, e.fe, e.data, e.cnt}) begin
               fails++;
               $display("FAIL np_pulse: got dv=%b pe=%b fe=%b out=%h cnt=%0d, required dv=%b pe=%b fe=%b out=%h cnt=%0d",
                        dv1, pe1, fe1, po1, cnt1, e.dv, e.pe, e.fe, e.data, e.cnt);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic drive_line(input int which, input logic v);
      if (which == 0) ser0 = v;
      else            ser1 = v;
   endtask

   task automatic hold(input int which, input logic v, input int n);
      drive_line(which, v);
      repeat (n) @(negedge clock);
   endtask

   task automatic push_exp(input int which, input logic dv, input logic pe, input logic fe);
      exp_t e;
      e.dv = dv; e.pe = pe; e.fe = fe;
      e.data = m_out[which]; e.cnt = m_cnt[which];
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
   endtask

   // Drives one frame starting at a negedge; t0 is the edge that first sees the start bit.
   task automatic send_frame(input int which, input logic [7:0] d, input logic par_ok,
                             input logic stop_bit, output int t0);
      logic pen, p, perr;
      pen  = (which == 0);
      p    = par_ok ? ^d : ~^d;
      perr = pen && !par_ok;
      if (stop_bit) begin
         if (perr) push_exp(which, 1'b0, 1'b1, 1'b0);
         else begin
            m_out[which] = d;
            m_cnt[which] = m_cnt[which] + 8'd1;
            push_exp(which, 1'b1, 1'b0, 1'b0);
         end
      end else begin
         push_exp(which, 1'b0, perr, 1'b1);
      end
      t0 = cyc + 1;
      hold(which, 1'b0, C);
      for (int i = 0; i < 8; i++) hold(which, d[i], C);
      if (pen) hold(which, p, C);
      hold(which, stop_bit, C);
   endtask

   task automatic test_reset();
      int bad;
      rst0 = 1'b1; rst1 = 1'b1; ser0 = 1'b1; ser1 = 1'b1;
      repeat (3) @(negedge clock);
      rst0 = 1'b0; rst1 = 1'b0;
      m_out[0] = 8'h00; m_out[1] = 8'h00; m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
      tests++;
      if ({po0, cnt0, busy0, dv0, pe0, fe0} !== {8'h00, 8'd0, 4'b0000}) begin
         fails++;
         $display("FAIL reset_dut: out=%h cnt=%0d busy=%b pulses=%b%b%b, required all zero",
                  po0, cnt0, busy0, dv0, pe0, fe0);
      end
      tests++;
      if ({po1, cnt1, busy1, dv1, pe1, fe1} !== {8'h00, 8'd0, 4'b0000}) begin
         fails++;
         $display("FAIL reset_np: out=%h cnt=%0d busy=%b pulses=%b%b%b, required all zero",
                  po1, cnt1, busy1, dv1, pe1, fe1);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (busy0 || busy1 || dv0 || pe0 || fe0 || dv1 || pe1 || fe1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL reset_idle: %0d cycles with busy or pulse, required 0", bad);
      end
   endtask

   task automatic test_good_frame();
      int t0;
      last_dv_cyc0 = -1;
      send_frame(0, 8'h48, 1'b1, 1'b1, t0);
      tests++;
      if (last_dv_cyc0 - t0 !== 42) begin
         fails++;
         $display("FAIL good_latency: data_valid at t0+%0d, required t0+42", last_dv_cyc0 - t0);
      end
      tests++;
      if ({po0, cnt0, busy0} !== {8'h48, 8'd1, 1'b0}) begin
         fails++;
         $display("FAIL good_state: out=%h cnt=%0d busy=%b, required out=48 cnt=1 busy=0",
                  po0, cnt0, busy0);
      end
      repeat (5) @(negedge clock);
   endtask

   task automatic test_glitch();
      logic [2:0] b;
      drive_line(0, 1'b0);
      @(negedge clock);
      drive_line(0, 1'b1);
      b[2] = busy0;
      @(negedge clock);
      b[1] = busy0;
      @(negedge clock);
      b[0] = busy0;
      tests++;
      if (b !== 3'b110) begin
         fails++;
         $display("FAIL glitch_busy: busy sequence %b, required 110", b);
      end
      repeat (10) @(negedge clock);
      tests++;
      if ({po0, cnt0} !== {m_out[0], m_cnt[0]}) begin
         fails++;
         $display("FAIL glitch_hold: out=%h cnt=%0d, required out=%h cnt=%0d",
                  po0, cnt0, m_out[0], m_cnt[0]);
      end
   endtask

   task automatic test_parity_error();
      int t0;
      send_frame(0, 8'h41, 1'b0, 1'b1, t0);
      repeat (3) @(negedge clock);
      tests++;
      if ({po0, cnt0, busy0} !== {8'h48, 8'd1, 1'b0}) begin
         fails++;
         $display("FAIL parity_hold: out=%h cnt=%0d busy=%b, required out=48 cnt=1 busy=0",
                  po0, cnt0, busy0);
      end
   endtask

   task automatic test_frame_error();
      int t0, low_idle;
      send_frame(0, 8'h2B, 1'b1, 1'b0, t0);
      low_idle = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (!busy0) low_idle++;
      end
      tests++;
      if (low_idle !== 0) begin
         fails++;
         $display("FAIL frame_busy: busy low on %0d cycles of held-low line, required 0", low_idle);
      end
      hold(0, 1'b1, 2);
      tests++;
      if (busy0 !== 1'b0) begin
         fails++;
         $display("FAIL frame_release: busy=%b after line high, required 0", busy0);
      end
      repeat (4) @(negedge clock);
      send_frame(0, 8'h2B, 1'b1, 1'b1, t0);
      tests++;
      if ({po0, cnt0} !== {8'h2B, 8'd2}) begin
         fails++;
         $display("FAIL frame_recover: out=%h cnt=%0d, required out=2b cnt=2", po0, cnt0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      hold(0, 1'b0, C);
      for (int i = 0; i < 4; i++) hold(0, i[0], C);
      rst0 = 1'b1;
      drive_line(0, 1'b1);
      repeat (2) @(negedge clock);
      rst0 = 1'b0;
      m_out[0] = 8'h00; m_cnt[0] = 8'd0;
      tests++;
      if ({po0, cnt0, busy0} !== {8'h00, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL midreset_state: out=%h cnt=%0d busy=%b, required all zero", po0, cnt0, busy0);
      end
      repeat (4) @(negedge clock);
      send_frame(0, 8'h2B, 1'b1, 1'b1, t0);
      tests++;
      if ({po0, cnt0} !== {8'h2B, 8'd1}) begin
         fails++;
         $display("FAIL midreset_frame: out=%h cnt=%0d, required out=2b cnt=1", po0, cnt0);
      end
   endtask

   task automatic test_back_to_back();
      int         t0;
      logic [7:0] start_cnt;
      start_cnt = cnt1;
      for (int i = 0; i < 256; i++) send_frame(1, 8'($urandom_range(0, 255)), 1'b1, 1'b1, t0);
      repeat (3) @(negedge clock);
      tests++;
      if (cnt1 !== start_cnt) begin
         fails++;
         $display("FAIL b2b_wrap: cnt=%0d after 256 frames, required %0d", cnt1, start_cnt);
      end
   endtask

   task automatic test_drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (q0.size() + q1.size() !== 0) begin
         fails++;
         $display("FAIL drain: %0d expected pulses never seen, required 0", q0.size() + q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_glitch();
      test_parity_error();
      test_frame_error();
      test_reset_mid_frame();
      test_back_to_back();
      test_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
